// File: rtl/axi_ni_request_packetizer_if.sv
// Request, AXI W and NoC flit signals of the initiator NI request packetizer.
// master drives requests/beats and accepts flits; slave is the packetizer.
interface axi_ni_request_packetizer_if #(
    parameter int FLIT_WIDTH = 32,
    parameter int AXIWDATAWD = 32,
    parameter int ADDRWD     = 32,
    parameter int ROUTEWD    = 12,
    parameter int BLEN_WD    = 5,
    parameter int INCR_WD    = 3,
    parameter int SEQ_WD     = 2,
    parameter int CMD_WD     = 3
);
    logic                      req_valid;
    logic                      req_ready;
    logic [CMD_WD-1:0]         command;
    logic [ADDRWD-1:0]         address;
    logic [BLEN_WD-1:0]        burst_length;
    logic [INCR_WD-1:0]        burst_increment;
    logic [SEQ_WD-1:0]         burst_sequence;
    logic                      burst_precise;
    logic [AXIWDATAWD/8-1:0]   byte_enables;
    logic [ROUTEWD-1:0]        route;
    logic [AXIWDATAWD-1:0]     wdata;
    logic [AXIWDATAWD/8-1:0]   wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic [FLIT_WIDTH-1:0]     flit_out;
    logic                      flit_valid;
    logic                      flit_ready;
    logic                      proto_err;

    modport master (
        output req_valid, command, address, burst_length,
        output burst_increment, burst_sequence, burst_precise,
        output byte_enables, route,
        output wdata, wstrb, wlast, wvalid, flit_ready,
        input  req_ready, wready, flit_out, flit_valid, proto_err
    );

    modport slave (
        input  req_valid, command, address, burst_length,
        input  burst_increment, burst_sequence, burst_precise,
        input  byte_enables, route,
        input  wdata, wstrb, wlast, wvalid, flit_ready,
        output req_ready, wready, flit_out, flit_valid, proto_err
    );
endinterface

// File: rtl/axi_ni_request_packetizer.sv
// Serialises one encoded AXI request (and its W beats for writes) into
// header/body/tail NoC flits through a single registered output stage.
module axi_ni_request_packetizer #(
    parameter int FLIT_WIDTH = 32,
    parameter int AXIWDATAWD = 32,
    parameter int ADDRWD     = 32,
    parameter int ROUTEWD    = 12,
    parameter int BLEN_WD    = 5,
    parameter int INCR_WD    = 3,
    parameter int SEQ_WD     = 2,
    parameter int CMD_WD     = 3,
    parameter logic [CMD_WD-1:0] PACKETCMDWRNP = CMD_WD'(1)
) (
    input logic                    clock,
    input logic                    reset,
    axi_ni_request_packetizer_if.slave bus
);
    localparam int FTYPEWD    = 2;
    localparam int BASE_WIDTH = FLIT_WIDTH - FTYPEWD;
    localparam int STRBWD     = AXIWDATAWD / 8;
    localparam int WORDWD     = AXIWDATAWD + STRBWD;
    localparam int DATA_FLITS = (WORDWD + BASE_WIDTH - 1) / BASE_WIDTH;
    localparam int PADWD      = DATA_FLITS * BASE_WIDTH;
    localparam int HOLDWD     = (DATA_FLITS > 1) ? PADWD - BASE_WIDTH : 1;
    localparam int SUB_WD     = (DATA_FLITS > 1) ? $clog2(DATA_FLITS) : 1;
    localparam int BEATWD     = BLEN_WD + 1;

    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_TAIL = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        HDR2,
        WDATA
    } state_e;

    state_e                  state_q, state_d;
    logic [BASE_WIDTH-1:0]   h0_q, h0_d;
    logic [BASE_WIDTH-1:0]   h1_q, h1_d;
    logic [BASE_WIDTH-1:0]   h2_q, h2_d;
    logic                    is_wr_q, is_wr_d;
    logic [BEATWD-1:0]       beats_q, beats_d;
    logic [SUB_WD-1:0]       sub_q, sub_d;
    logic [HOLDWD-1:0]       hold_q, hold_d;
    logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
    logic                    flit_valid_q, flit_valid_d;
    logic                    req_ready_q, req_ready_d;
    logic                    proto_err_q, proto_err_d;

    logic                    load;
    logic                    wready_c;
    logic                    fin;
    logic                    last_sub;
    logic [PADWD-1:0]        word;
    logic [BASE_WIDTH-1:0]   sub_payload;

    always_comb begin
        state_d      = state_q;
        h0_d         = h0_q;
        h1_d         = h1_q;
        h2_d         = h2_q;
        is_wr_d      = is_wr_q;
        beats_d      = beats_q;
        sub_d        = sub_q;
        hold_d       = hold_q;
        flit_d       = flit_q;
        proto_err_d  = proto_err_q;
        wready_c     = 1'b0;
        load         = !flit_valid_q || bus.flit_ready;
        flit_valid_d = flit_valid_q && !bus.flit_ready;
        word         = PADWD'({bus.wstrb, bus.wdata});
        fin          = (beats_q == BEATWD'(1));
        last_sub     = (sub_q == SUB_WD'(DATA_FLITS - 1));
        sub_payload  = '0;
        for (int k = 1; k < DATA_FLITS; k++) begin
            if (int'(sub_q) == k) begin
                sub_payload = hold_q[(k-1)*BASE_WIDTH +: BASE_WIDTH];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    h0_d = BASE_WIDTH'({bus.command, bus.burst_length,
                                        bus.burst_sequence,
                                        bus.burst_increment,
                                        bus.burst_precise, 4'b0,
                                        bus.route});
                    h1_d = bus.address[BASE_WIDTH-1:0];
                    h2_d = BASE_WIDTH'({bus.byte_enables,
                                        bus.address[ADDRWD-1:BASE_WIDTH]});
                    is_wr_d = (bus.command == PACKETCMDWRNP);
                    // burst_length of 0 encodes the full 2^BLEN_WD beats
                    beats_d = {bus.burst_length == '0, bus.burst_length};
                    state_d = HDR0;
                end
            end
            HDR0: begin
                if (load) begin
                    flit_d       = {FT_HEAD, h0_q};
                    flit_valid_d = 1'b1;
                    state_d      = HDR1;
                end
            end
            HDR1: begin
                if (load) begin
                    flit_d       = {FT_BODY, h1_q};
                    flit_valid_d = 1'b1;
                    state_d      = HDR2;
                end
            end
            HDR2: begin
                if (load) begin
                    flit_d       = {is_wr_q ? FT_BODY : FT_TAIL, h2_q};
                    flit_valid_d = 1'b1;
                    sub_d        = '0;
                    state_d      = is_wr_q ? WDATA : IDLE;
                end
            end
            WDATA: begin
                if (load) begin
                    if (sub_q == '0) begin
                        wready_c = 1'b1;
                        if (bus.wvalid) begin
                            hold_d  = word[PADWD-1 -: HOLDWD];
                            beats_d = beats_q - BEATWD'(1);
                            if (bus.wlast != fin) begin
                                proto_err_d = 1'b1;
                            end
                            flit_d = {(fin && DATA_FLITS == 1) ?
                                      FT_TAIL : FT_BODY,
                                      word[BASE_WIDTH-1:0]};
                            flit_valid_d = 1'b1;
                            if (DATA_FLITS == 1) begin
                                if (fin) state_d = IDLE;
                            end else begin
                                sub_d = SUB_WD'(1);
                            end
                        end
                    end else begin
                        flit_d = {(last_sub && beats_q == '0) ?
                                  FT_TAIL : FT_BODY, sub_payload};
                        flit_valid_d = 1'b1;
                        sub_d = last_sub ? '0 : sub_q + SUB_WD'(1);
                        if (last_sub && beats_q == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            h0_q         <= '0;
            h1_q         <= '0;
            h2_q         <= '0;
            is_wr_q      <= 1'b0;
            beats_q      <= '0;
            sub_q        <= '0;
            hold_q       <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            req_ready_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            h0_q         <= h0_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            is_wr_q      <= is_wr_d;
            beats_q      <= beats_d;
            sub_q        <= sub_d;
            hold_q       <= hold_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
            req_ready_q  <= req_ready_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.wready     = wready_c;
    assign bus.flit_out   = flit_q;
    assign bus.flit_valid = flit_valid_q;
    assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_axi_ni_request_packetizer.sv
// Directed bench for axi_ni_request_packetizer: read, write, backpressure,
// W starvation, wlast framing errors, full-length burst and reset abort.
module tb_axi_ni_request_packetizer;
    localparam logic [2:0] CMD_RD = 3'b000;
    localparam logic [2:0] CMD_WR = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_ni_request_packetizer_if bus ();

    axi_ni_request_packetizer dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int acc_cyc, first_cyc, last_cyc, wbeats, gap_bubbles;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int i);
        beat_data = 32'h1111_1111 * (i + 1);
    endfunction

    function automatic int nbeats(input logic [2:0] cmd,
                                  input logic [4:0] blen);
        if (cmd != CMD_WR) nbeats = 0;
        else nbeats = (blen == 5'd0) ? 32 : int'(blen);
    endfunction

    // Reference flit stream built from the packet format description.
    task automatic build_exp(input logic [2:0] cmd, input logic [31:0] addr,
                             input logic [4:0] blen, input logic [1:0] seq,
                             input logic [2:0] incr, input logic prec,
                             input logic [3:0] be, input logic [11:0] rt);
        logic [29:0] h0;
        logic [59:0] w;
        int nb;
        nb = nbeats(cmd, blen);
        h0 = {cmd, blen, seq, incr, prec, 4'b0, rt};
        exp_q.delete();
        exp_q.push_back({2'b10, h0});
        exp_q.push_back({2'b00, addr[29:0]});
        exp_q.push_back({(nb == 0) ? 2'b01 : 2'b00,
                         24'b0, be, addr[31:30]});
        for (int i = 0; i < nb; i++) begin
            w = {24'b0, 4'hF, beat_data(i)};
            exp_q.push_back({2'b00, w[29:0]});
            exp_q.push_back({(i == nb - 1) ? 2'b01 : 2'b00, w[59:30]});
        end
    endtask

    task automatic run_pkt(input string tag, input logic [2:0] cmd,
                           input logic [31:0] addr, input logic [4:0] blen,
                           input logic [11:0] rt, input int toggle,
                           input int gap_beat, input int wlast_beat,
                           input int abort_at);
        int n, nb, beat, cyc, gap_left, extra;
        bit gap_done, accepted, stalled;
        logic [31:0] stall_val;
        n = exp_q.size();
        nb = nbeats(cmd, blen);
        beat = 0; cyc = 0; gap_left = 0; gap_done = 0;
        accepted = 0; stalled = 0; stall_val = '0;
        got_q.delete();
        wbeats = 0; gap_bubbles = 0;
        first_cyc = -1; acc_cyc = -1; last_cyc = -1;
        while (got_q.size() < n && cyc < 3000) begin
            @(negedge clk);
            bus.req_valid       = !accepted;
            bus.command         = cmd;
            bus.address         = addr;
            bus.burst_length    = blen;
            bus.burst_sequence  = 2'b01;
            bus.burst_increment = 3'b010;
            bus.burst_precise   = 1'b1;
            bus.byte_enables    = 4'hF;
            bus.route           = rt;
            bus.flit_ready      = (toggle != 0) ? cyc[0] : 1'b1;
            if (gap_beat >= 0 && beat == gap_beat && !gap_done) begin
                gap_left = 5;
                gap_done = 1;
            end
            bus.wvalid = (beat < nb) && (gap_left == 0);
            bus.wdata  = beat_data(beat);
            bus.wstrb  = 4'hF;
            bus.wlast  = (beat + 1 == wlast_beat);
            #1;
            if (stalled) begin
                chk({tag, "_stall_valid"}, 64'(bus.flit_valid), 64'd1);
                chk({tag, "_stall_data"}, 64'(bus.flit_out), 64'(stall_val));
            end
            stalled   = bus.flit_valid && !bus.flit_ready;
            stall_val = bus.flit_out;
            if (gap_left > 0) begin
                if (!bus.flit_valid) gap_bubbles++;
                gap_left--;
            end
            if (bus.req_valid && bus.req_ready) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (bus.flit_valid && bus.flit_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got_q.push_back(bus.flit_out);
            end
            if (bus.wvalid && bus.wready) begin
                beat++;
                wbeats++;
            end
            if (abort_at >= 0 && got_q.size() == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, "_rst_flit_valid"}, 64'(bus.flit_valid), 64'd0);
                chk({tag, "_rst_wready"}, 64'(bus.wready), 64'd0);
                chk({tag, "_rst_req_ready"}, 64'(bus.req_ready), 64'd0);
                chk({tag, "_rst_flit_out"}, 64'(bus.flit_out), 64'd0);
                bus.req_valid = 1'b0;
                bus.wvalid    = 1'b0;
                return;
            end
            cyc++;
        end
        bus.req_valid = 1'b0;
        bus.wvalid    = 1'b0;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk($sformatf("%s_flit%0d", tag, i), 64'(got_q[i]),
                64'(exp_q[i]));
        end
        chk({tag, "_wbeats"}, 64'(wbeats), 64'(nb));
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.flit_ready = 1'b1;
            #1;
            if (bus.flit_valid) extra++;
        end
        chk({tag, "_extra_flits"}, 64'(extra), 64'd0);
        chk({tag, "_req_ready_after"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        bus.req_valid = 0; bus.command = '0; bus.address = '0;
        bus.burst_length = '0; bus.burst_increment = '0;
        bus.burst_sequence = '0; bus.burst_precise = 0;
        bus.byte_enables = '0; bus.route = '0; bus.wdata = '0;
        bus.wstrb = '0; bus.wlast = 0; bus.wvalid = 0; bus.flit_ready = 0;
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_wready", 64'(bus.wready), 64'd0);
        chk("reset_flit_valid", 64'(bus.flit_valid), 64'd0);
        chk("reset_flit_out", 64'(bus.flit_out), 64'd0);
        chk("reset_proto_err", 64'(bus.proto_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Read: hand-computed header, body and tail flits
        exp_q.delete();
        exp_q.push_back(32'h8055_00A5);
        exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'h4000_003E);
        run_pkt("read", CMD_RD, 32'h8000_0104, 5'd1, 12'h0A5, 0, -1, 0, -1);
        chk("read_latency", 64'(first_cyc - acc_cyc), 64'd2);
        chk("read_no_bubble", 64'(last_cyc - first_cyc), 64'd2);

        build_exp(CMD_WR, 32'h1234_5678, 5'd4, 2'b01, 3'b010, 1'b1, 4'hF,
                  12'h3C2);
        chk("write_first_data", 64'(exp_q[3]), 64'h0000_0000_1111_1111);
        chk("write_second_data", 64'(exp_q[4]), 64'h0000_0000_0000_003C);
        run_pkt("write", CMD_WR, 32'h1234_5678, 5'd4, 12'h3C2, 0, -1, 4, -1);
        chk("write_latency", 64'(first_cyc - acc_cyc), 64'd2);
        chk("write_no_bubble", 64'(last_cyc - first_cyc), 64'd10);
        chk("write_proto_err", 64'(bus.proto_err), 64'd0);

        run_pkt("bp", CMD_WR, 32'h1234_5678, 5'd4, 12'h3C2, 1, -1, 4, -1);
        chk("bp_proto_err", 64'(bus.proto_err), 64'd0);

        run_pkt("starve", CMD_WR, 32'h1234_5678, 5'd4, 12'h3C2, 0, 2, 4, -1);
        chk("starve_bubbles", 64'(gap_bubbles >= 2), 64'd1);
        chk("starve_proto_err", 64'(bus.proto_err), 64'd0);

        build_exp(CMD_WR, 32'h0000_0040, 5'd0, 2'b01, 3'b010, 1'b1, 4'hF,
                  12'h111);
        chk("blen0_size", 64'(exp_q.size()), 64'd67);
        run_pkt("blen0", CMD_WR, 32'h0000_0040, 5'd0, 12'h111, 0, -1, 32, -1);
        chk("blen0_proto_err", 64'(bus.proto_err), 64'd0);

        build_exp(CMD_WR, 32'h1234_5678, 5'd4, 2'b01, 3'b010, 1'b1, 4'hF,
                  12'h3C2);
        run_pkt("wlast_err", CMD_WR, 32'h1234_5678, 5'd4, 12'h3C2,
                0, -1, 2, -1);
        chk("wlast_err_proto_err", 64'(bus.proto_err), 64'd1);

        run_pkt("abort", CMD_WR, 32'h1234_5678, 5'd4, 12'h3C2, 0, -1, 4, 5);
        chk("abort_proto_err", 64'(bus.proto_err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        exp_q.delete();
        exp_q.push_back(32'h8055_00A5);
        exp_q.push_back(32'h0000_0104);
        exp_q.push_back(32'h4000_003E);
        run_pkt("read2", CMD_RD, 32'h8000_0104, 5'd1, 12'h0A5, 0, -1, 0, -1);
        chk("read2_latency", 64'(first_cyc - acc_cyc), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_ni_request_packetizer.md
Name: axi_ni_request_packetizer

Overview:
- Sequential stage directly downstream of the AXI NI request encoder in the initiator NI.
- Latches one encoded request (command, address, burst fields, byte enables) plus its route.
- For writes, it consumes the AXI W beats.
- It serialises the request into NoC flits (header, body and tail) on a registered valid/ready flit output towards the switch.

Parameters:
- FLIT_WIDTH, 32: flit width. BASE_WIDTH = FLIT_WIDTH - `FTYPEWD` (2), so 30.
- AXIWDATAWD, 32: W data width. Strobe width is AXIWDATAWD/8.
- ADDRWD, 32: packet address width. Must be greater than BASE_WIDTH.
- ROUTEWD, 12: source-route field width.
- BLEN_WD, 5: burst_length width.
- INCR_WD, 3: burst_increment width.
- SEQ_WD, 2: burst_sequence width.
- CMD_WD, 3: command width.
- Derived: DATA_FLITS = ceil((AXIWDATAWD + AXIWDATAWD/8) / BASE_WIDTH), which is 2 at the defaults.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: encoded request present.
- req_ready, out, 1: request accepted when req_valid and req_ready are both high.
- command, in, CMD_WD: from the encoder. PACKETCMDWRNP marks a write; any other value is a read.
- address, in, ADDRWD: aligned request address.
- burst_length, in, BLEN_WD: number of beats, 1..2^BLEN_WD.
- burst_increment, in, INCR_WD: encoded beat size.
- burst_sequence, in, SEQ_WD: encoded burst type.
- burst_precise, in, 1: precise-burst flag.
- byte_enables, in, AXIWDATAWD/8: first-beat byte enables.
- route, in, ROUTEWD: destination route.
- wdata, in, AXIWDATAWD: AXI W data.
- wstrb, in, AXIWDATAWD/8: AXI W strobes.
- wlast, in, 1: AXI W last.
- wvalid, in, 1: AXI W valid.
- wready, out, 1: AXI W ready.
- flit_out, out, FLIT_WIDTH: flit to the NoC.
- flit_valid, out, 1: flit_out is valid.
- flit_ready, in, 1: NoC accepts the flit.
- proto_err, out, 1: sticky wlast framing error.

Behaviour:
- Reset, asynchronous and active-low. All outputs go to 0: req_ready, wready, flit_valid, flit_out and proto_err. The FSM goes to IDLE and all counters clear.
- Reset asserted mid-packet aborts the packet immediately. No tail flit is emitted.
- Flit type occupies flit[FLIT_WIDTH-1 -: 2]:
  - HEADER = 2'b10 for the first flit.
  - BODY = 2'b00 for intermediate flits.
  - TAIL = 2'b01 for the last flit.
- Payload occupies flit[BASE_WIDTH-1:0]. It is LSB-aligned and zero-padded.
- Header flit payloads:
  - H0 = {command, burst_length, burst_sequence, burst_increment, burst_precise, 4'b0, route}. This is 30 bits at the defaults, with route at [11:0].
  - H1 = address[BASE_WIDTH-1:0].
  - H2 = {byte_enables, address[ADDRWD-1:BASE_WIDTH]}.
- Read packet: H0 (HEADER), H1 (BODY), H2 (TAIL). Exactly 3 flits.
- Write packet: H0, H1, H2 (BODY), then DATA_FLITS flits per beat. Total flits = 3 + burst_length*DATA_FLITS. Only the final flit is TAIL.
- Data flits: beat word W = {wstrb, wdata}. Data flit k carries W[k*BASE_WIDTH +: BASE_WIDTH], k = 0..DATA_FLITS-1, with k = 0 sent first.
- FSM states:
  - IDLE: req_ready = 1. On acceptance, latch all request fields, load beats_left = burst_length (0 encodes 2^BLEN_WD), go to HDR0.
  - HDR0, HDR1, HDR2: one flit each.
  - After HDR2, a read returns to IDLE and a write goes to WDATA.
  - WDATA: per beat, emit data flits. When beats_left reaches 0 after the final flit, return to IDLE.
- Output is a single register stage. A new flit is loaded when (!flit_valid || flit_ready). flit_valid holds and flit_out stays stable while flit_ready = 0.
- Latency: request accepted at edge N puts H0 on flit_out at N+1. With flit_ready held at 1, one flit is sent per cycle with no bubbles.
- req_ready = 0 in every state except IDLE. The cycle after a TAIL handshake is back in IDLE, so back-to-back packets have at most one idle cycle between them.
- wready = 1 only in WDATA, when the sub-flit index is 0 and the output register can load. The beat is captured into a holding register.
- Data flit 0 is emitted in the same load as the beat capture. The remaining sub-flits come from the holding register.
- wvalid = 0 in WDATA inserts bubbles (flit_valid drops). It is not an error.
- Framing is governed by burst_length only; wlast never alters the flit count.
  - wlast = 1 on a non-final beat sets proto_err.
  - wlast = 0 on the final beat sets proto_err.
  - proto_err clears only on reset.
- W beats presented outside WDATA are not accepted (wready = 0).

Test Plan:
- Read: command=READ, address=0x8000_0104, burst_length=1, route=0x0A5, flit_ready=1 → exactly 3 flits starting at N+1: H0 type 10, H1 type 00 = 0x0000_0104, H2 type 01 payload = {be, 2'b10}. req_ready returns to 1 after the tail.
- Write: burst_length=4, wdata=0x11111111..0x44444444, wstrb=0xF, wlast on beat 4 → 11 flits, TAIL only on the last. Each beat split as W[29:0], then W[35:30]. wready pulses once per 2 flits. proto_err=0.
- Backpressure: same write, flit_ready toggled 0/1 every cycle → flit_out stable while stalled, identical flit sequence, no flit lost or duplicated.
- W starvation: wvalid deasserted for 5 cycles mid-burst → flit_valid=0 during the gap, then the sequence resumes correctly.
- Framing errors: wlast on beat 2 of 4 → proto_err=1 and all 11 flits still sent. A separate run with burst_length=0 → 32 beats, 67 flits.
- Reset mid-packet: reset low during WDATA → flit_valid, wready and req_ready go to 0 asynchronously. After release, a new read packet is emitted correctly.
